// File: rtl/vga_timing_gen.sv
// VGA raster timing source: free-running pixel/line counters, visible-area decode,
// and a single output register stage for blanked colour plus hsync/vsync.
module vga_timing_gen #(
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic       clk25,
    input  logic       Reset,
    output logic [9:0] xpos,
    output logic [9:0] ypos,
    output logic       visible,
    output logic       frame_end,
    input  logic [2:0] red_in,
    input  logic [2:0] green_in,
    input  logic [1:0] blue_in,
    output logic [2:0] vga_red,
    output logic [2:0] vga_green,
    output logic [1:0] vga_blue,
    output logic       hsync,
    output logic       vsync
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       frame_end_q, frame_end_d;
    logic [2:0] red_q, red_d;
    logic [2:0] green_q, green_d;
    logic [1:0] blue_q, blue_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       visible_s;

    // Next-state counters, visible decode and the values the output stage samples
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        frame_end_d = 1'b0;
        red_d       = 3'd0;
        green_d     = 3'd0;
        blue_d      = 2'd0;
        hsync_d     = ~SYNC_ACTIVE;
        vsync_d     = ~SYNC_ACTIVE;

        if (x_q == H_LAST) begin
            x_d = 10'd0;
            if (y_q == V_LAST) begin
                y_d = 10'd0;
            end else begin
                y_d = y_q + 10'd1;
            end
        end else begin
            x_d = x_q + 10'd1;
            y_d = y_q;
        end

        // Registered off the next counter values so it lines up with (0, V_VISIBLE)
        frame_end_d = (x_d == 10'd0) && (y_d == V_VIS);

        visible_s = (x_q < H_VIS) && (y_q < V_VIS);

        if (visible_s) begin
            red_d   = red_in;
            green_d = green_in;
            blue_d  = blue_in;
        end else begin
            red_d   = 3'd0;
            green_d = 3'd0;
            blue_d  = 2'd0;
        end

        if ((x_q >= HS_FIRST) && (x_q <= HS_LAST)) begin
            hsync_d = SYNC_ACTIVE;
        end else begin
            hsync_d = ~SYNC_ACTIVE;
        end

        if ((y_q >= VS_FIRST) && (y_q <= VS_LAST)) begin
            vsync_d = SYNC_ACTIVE;
        end else begin
            vsync_d = ~SYNC_ACTIVE;
        end
    end

    // Counter, frame marker and pin registers
    always_ff @(posedge clk25 or negedge Reset) begin
        if (!Reset) begin
            x_q         <= 10'd0;
            y_q         <= 10'd0;
            frame_end_q <= 1'b0;
            red_q       <= 3'd0;
            green_q     <= 3'd0;
            blue_q      <= 2'd0;
            hsync_q     <= ~SYNC_ACTIVE;
            vsync_q     <= ~SYNC_ACTIVE;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            frame_end_q <= frame_end_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
        end
    end

    assign xpos      = x_q;
    assign ypos      = y_q;
    assign visible   = visible_s;
    assign frame_end = frame_end_q;
    assign vga_red   = red_q;
    assign vga_green = green_q;
    assign vga_blue  = blue_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny-raster instance
// driven with random colour, compared every cycle against arithmetic raster positions.
module tb_vga_timing_gen;

    logic       clk25;
    logic       Reset;
    logic [2:0] red_in, green_in;
    logic [1:0] blue_in;

    logic [9:0] d_x, d_y, s_x, s_y;
    logic       d_vis, d_fe, d_hs, d_vs, s_vis, s_fe, s_hs, s_vs;
    logic [2:0] d_r, d_g, s_r, s_g;
    logic [1:0] d_b, s_b;

    int vectors;
    int miscompares;
    int k;
    bit in_rst;
    logic [2:0] pr, pg;
    logic [1:0] pb;

    vga_timing_gen dut_def (
        .clk25(clk25), .Reset(Reset), .xpos(d_x), .ypos(d_y), .visible(d_vis),
        .frame_end(d_fe), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .vga_red(d_r), .vga_green(d_g), .vga_blue(d_b), .hsync(d_hs), .vsync(d_vs)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) dut_sml (
        .clk25(clk25), .Reset(Reset), .xpos(s_x), .ypos(s_y), .visible(s_vis),
        .frame_end(s_fe), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .vga_red(s_r), .vga_green(s_g), .vga_blue(s_b), .hsync(s_hs), .vsync(s_vs)
    );

    initial clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    task automatic cmp(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s at k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    // Expected raster position is simply k cycles since release, folded by the totals
    task automatic check_dut(input string nm,
                             input int hv, input int hf, input int hsn, input int hb,
                             input int vv, input int vf, input int vsn, input int vb,
                             input logic [9:0] xo, input logic [9:0] yo,
                             input logic viso, input logic feo,
                             input logic [2:0] ro, input logic [2:0] go, input logic [1:0] bo,
                             input logic hso, input logic vso);
        int ht, vt, x, y, px, py;
        logic ev, ef, ehs, evs, pv;
        logic [2:0] er, eg;
        logic [1:0] eb;
        ht = hv + hf + hsn + hb;
        vt = vv + vf + vsn + vb;
        x  = in_rst ? 0 : k % ht;
        y  = in_rst ? 0 : (k / ht) % vt;
        ev = (x < hv) && (y < vv);
        ef = !in_rst && (x == 0) && (y == vv);
        if (in_rst || k == 0) begin
            er = 3'd0; eg = 3'd0; eb = 2'd0; ehs = 1'b1; evs = 1'b1;
        end else begin
            px  = (k - 1) % ht;
            py  = ((k - 1) / ht) % vt;
            pv  = (px < hv) && (py < vv);
            er  = pv ? pr : 3'd0;
            eg  = pv ? pg : 3'd0;
            eb  = pv ? pb : 2'd0;
            ehs = !((px >= hv + hf) && (px < hv + hf + hsn));
            evs = !((py >= vv + vf) && (py < vv + vf + vsn));
        end
        cmp({nm, ".xpos"},      xo,   10'(x));
        cmp({nm, ".ypos"},      yo,   10'(y));
        cmp({nm, ".visible"},   {9'd0, viso}, {9'd0, ev});
        cmp({nm, ".frame_end"}, {9'd0, feo},  {9'd0, ef});
        cmp({nm, ".vga_red"},   {7'd0, ro},   {7'd0, er});
        cmp({nm, ".vga_green"}, {7'd0, go},   {7'd0, eg});
        cmp({nm, ".vga_blue"},  {8'd0, bo},   {8'd0, eb});
        cmp({nm, ".hsync"},     {9'd0, hso},  {9'd0, ehs});
        cmp({nm, ".vsync"},     {9'd0, vso},  {9'd0, evs});
    endtask

    task automatic check_both();
        check_dut("def", 640, 16, 96, 48, 480, 10, 2, 33,
                  d_x, d_y, d_vis, d_fe, d_r, d_g, d_b, d_hs, d_vs);
        check_dut("sml", 8, 2, 2, 2, 4, 1, 1, 1,
                  s_x, s_y, s_vis, s_fe, s_r, s_g, s_b, s_hs, s_vs);
    endtask

    // mode 0: random colour, 1: all ones, 2: red follows the default xpos[2:0]
    task automatic drive(input int mode);
        case (mode)
            1: begin red_in = 3'd7; green_in = 3'd7; blue_in = 2'd3; end
            2: begin
                red_in   = 3'((k % 800) % 8);
                green_in = 3'($urandom_range(0, 7));
                blue_in  = 2'($urandom_range(0, 3));
            end
            default: begin
                red_in   = 3'($urandom_range(0, 7));
                green_in = 3'($urandom_range(0, 7));
                blue_in  = 2'($urandom_range(0, 3));
            end
        endcase
    endtask

    task automatic step(input int mode);
        pr = red_in; pg = green_in; pb = blue_in;
        @(posedge clk25);
        k++;
        @(negedge clk25);
        check_both();
        drive(mode);
    endtask

    initial begin
        vectors = 0; miscompares = 0; k = 0; in_rst = 1'b1;
        pr = 3'd0; pg = 3'd0; pb = 2'd0;
        Reset = 1'b0;
        red_in = 3'd5; green_in = 3'd6; blue_in = 2'd2;

        // Held in reset across edges: everything at reset values
        for (int i = 0; i < 3; i++) begin
            @(posedge clk25);
            @(negedge clk25);
            check_both();
        end

        Reset = 1'b1; in_rst = 1'b0; k = 0;
        check_both();
        drive(0);

        // Random colour up to default xpos=300, ypos=1
        for (int i = 0; i < 1100; i++) step(0);

        // Asynchronous reset between edges, mid-line
        #2 Reset = 1'b0; in_rst = 1'b1; k = 0;
        #1 check_both();
        @(posedge clk25);
        @(negedge clk25);
        check_both();
        Reset = 1'b1; in_rst = 1'b0; k = 0;
        check_both();
        drive(0);

        // After release: xpos 1,2,3 then keep going with random colour
        for (int i = 0; i < 900; i++) step(0);

        // Constant full-scale colour exposes the blanking windows
        drive(1);
        for (int i = 0; i < 1700; i++) step(1);

        // Red tracks the pixel column to show the one-cycle pin latency
        drive(2);
        for (int i = 0; i < 900; i++) step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
